// File: rtl/sound_arbiter.sv
// sound_arbiter: four-requester fixed-priority buzzer arbiter.
// A granted requester's note plays for dur_in[i] ticks of TICK_DIV clocks,
// followed by GAP_TICKS silent ticks before the next grant.
// Optional feature: define SOUND_ARB_PREEMPT_EN to let a higher-index request
// interrupt a note or gap in progress.
module sound_arbiter #(
  parameter int unsigned TICK_DIV  = 50000,
  parameter int unsigned GAP_TICKS = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [15:0] note_in,
  input  logic [31:0] dur_in,
  output logic [3:0]  ack,
  output logic [3:0]  note_sel,
  output logic        sound_en,
  output logic [1:0]  active_id,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLAY,
    ST_GAP
  } state_e;

  localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 1);
  localparam logic [7:0]  GAP_INIT  = 8'(GAP_TICKS);

  state_e      state_q, state_d;
  logic [15:0] presc_q, presc_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  ack_q, ack_d;
  logic [3:0]  note_sel_q, note_sel_d;
  logic        sound_en_q, sound_en_d;
  logic [1:0]  active_id_q, active_id_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        req_any;
  logic [1:0]  req_idx;
  logic        grant;
  logic        tick;
  logic [7:0]  grant_dur;

  // Fixed-priority encoder: the highest set request index wins.
  always_comb begin
    req_any = |req;
    req_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (req[i]) req_idx = 2'(i);
    end
  end

  assign grant_dur = dur_in[{req_idx, 3'b000} +: 8];

  // Next-state and registered-output logic for the IDLE/PLAY/GAP sequencer.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned
    // (which would infer a latch); combinational logic uses blocking '='.
    state_d     = state_q;
    presc_d     = presc_q;
    cnt_d       = cnt_q;
    ack_d       = 4'b0000;
    note_sel_d  = note_sel_q;
    sound_en_d  = sound_en_q;
    active_id_d = active_id_q;
    done_d      = 1'b0;
    grant       = 1'b0;
    tick        = (presc_q == PRESC_MAX);

    unique case (state_q)
      ST_IDLE: begin
        grant = req_any;
      end

      ST_PLAY: begin
        if (tick) begin
          presc_d = 16'd0;
          if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
        end else begin
          presc_d = presc_q + 16'd1;
        end
        // Zero-length notes expire on the first PLAY edge; others on the last wrap.
        if (cnt_q == 8'd0 || (tick && cnt_q == 8'd1)) begin
          sound_en_d = 1'b0;
          done_d     = 1'b1;
          presc_d    = 16'd0;
          cnt_d      = GAP_INIT;
          state_d    = (GAP_TICKS == 0) ? ST_IDLE : ST_GAP;
        end
      end

      ST_GAP: begin
        if (tick) begin
          presc_d = 16'd0;
          if (cnt_q <= 8'd1) begin
            cnt_d   = 8'd0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end else begin
          presc_d = presc_q + 16'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

`ifdef SOUND_ARB_PREEMPT_EN
    // A strictly higher-priority request interrupts a note or gap in progress.
    if (state_q != ST_IDLE && req_any && req_idx > active_id_q) grant = 1'b1;
`endif

    // A grant overrides any expiry decided above, so a preempted note never pulses done.
    if (grant) begin
      ack_d       = 4'b0001 << req_idx;
      active_id_d = req_idx;
      note_sel_d  = note_in[{req_idx, 2'b00} +: 4];
      cnt_d       = grant_dur;
      presc_d     = 16'd0;
      sound_en_d  = (grant_dur != 8'd0);
      done_d      = 1'b0;
      state_d     = ST_PLAY;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset clears everything without a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking '<=' so all flops update together.
    if (reset) begin
      state_q     <= ST_IDLE;
      presc_q     <= 16'd0;
      cnt_q       <= 8'd0;
      ack_q       <= 4'b0000;
      note_sel_q  <= 4'd0;
      sound_en_q  <= 1'b0;
      active_id_q <= 2'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      cnt_q       <= cnt_d;
      ack_q       <= ack_d;
      note_sel_q  <= note_sel_d;
      sound_en_q  <= sound_en_d;
      active_id_q <= active_id_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign ack       = ack_q;
  assign note_sel  = note_sel_q;
  assign sound_en  = sound_en_q;
  assign active_id = active_id_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_sound_arbiter.sv
// Self-checking bench for sound_arbiter (TICK_DIV=4, GAP_TICKS=1).
// Expectations follow SOUND_ARB_PREEMPT_EN when the bench is built with it.
module tb_sound_arbiter;

  localparam int TD  = 4;
  localparam int GAP = 1;
  localparam int BIG = 1 << 30;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] note_in;
  logic [31:0] dur_in;
  logic [3:0]  ack;
  logic [3:0]  note_sel;
  logic        sound_en;
  logic [1:0]  active_id;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  sound_arbiter #(.TICK_DIV(TD), .GAP_TICKS(GAP)) dut (
    .clk(clk), .reset(reset), .req(req), .note_in(note_in), .dur_in(dur_in),
    .ack(ack), .note_sel(note_sel), .sound_en(sound_en), .active_id(active_id),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // ---------------- reference model: time since the last grant ----------------
  int         m_t, m_end, m_idle, m_dur, m_id;
  logic [3:0] m_note;

  task automatic model_reset();
    m_t = BIG; m_end = -1; m_idle = 0; m_dur = 0; m_id = 0; m_note = 4'd0;
  endtask

  // Applies the rules for one rising edge with the inputs the DUT sampled.
  task automatic model_edge();
    int  hi;
    bit  idle, grant;
    hi    = -1;
    for (int i = 0; i < 4; i++) if (req[i]) hi = i;
    idle  = (m_t >= m_idle);
    grant = idle && (hi >= 0);
`ifdef SOUND_ARB_PREEMPT_EN
    if (!idle && hi > m_id) grant = 1'b1;
`endif
    if (grant) begin
      m_t    = 0;
      m_id   = hi;
      m_note = note_in[4*hi +: 4];
      m_dur  = int'(dur_in[8*hi +: 8]);
      m_end  = (m_dur == 0) ? 1 : m_dur * TD;
      m_idle = m_end + GAP * TD;
    end else if (m_t < BIG) begin
      m_t++;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [3:0] e_ack;
    e_ack = (m_t == 0) ? (4'b0001 << m_id) : 4'b0000;
    check("ack",       32'(ack),       32'(e_ack));
    check("note_sel",  32'(note_sel),  32'(m_note));
    check("sound_en",  32'(sound_en),  32'(m_dur > 0 && m_t < m_end));
    check("active_id", 32'(active_id), 32'(m_id));
    check("busy",      32'(busy),      32'(m_t < m_idle));
    check("done",      32'(done),      32'(m_t == m_end));
  endtask

  // One clock: model follows the edge, outputs are compared 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (busy && n < 3000) begin step(); n++; end
    check("drain_timeout", 32'(busy), 32'd0);
  endtask

  // ---------------- single-request vector table ----------------
  typedef struct {
    logic [3:0]  req;
    logic [15:0] note;
    logic [31:0] dur;
    logic [3:0]  e_ack;
    logic [3:0]  e_note;
    int          e_sound;
    int          e_busy;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int         sound_cnt, busy_cnt, done_cnt, ack_cnt, n, t_ack;
    logic [3:0] first_ack;
    bit         sound_hole;

    // {req, note_in, dur_in, ack, note_sel, sound cycles, busy cycles}
    vecs[0] = '{4'b0010, 16'h0050, 32'h0000_0300, 4'b0010, 4'h5, 12,   16};
    vecs[1] = '{4'b0101, 16'h0A00, 32'h0001_0000, 4'b0100, 4'hA, 4,    8};
    vecs[2] = '{4'b1000, 16'h7000, 32'h0000_0000, 4'b1000, 4'h7, 0,    5};
    vecs[3] = '{4'b0001, 16'h000F, 32'h0000_00FF, 4'b0001, 4'hF, 1020, 1024};
    vecs[4] = '{4'b1111, 16'h1234, 32'h0203_0405, 4'b1000, 4'h1, 8,    12};

    req = 4'b0000; note_in = 16'h0000; dur_in = 32'h0;
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk); #1; compare_all();
    @(negedge clk); reset = 1'b0;

    // Table: pulse one request pattern, then measure the whole note and gap.
    foreach (vecs[k]) begin
      req = vecs[k].req; note_in = vecs[k].note; dur_in = vecs[k].dur;
      step();
      req = 4'b0000;
      first_ack = ack;
      ack_cnt   = (ack != 0) ? 1 : 0;
      sound_cnt = sound_en ? 1 : 0;
      busy_cnt  = busy ? 1 : 0;
      done_cnt  = done ? 1 : 0;
      n = 0;
      while (busy && n < 2000) begin
        step(); n++;
        if (ack != 0) ack_cnt++;
        if (sound_en) sound_cnt++;
        if (busy) busy_cnt++;
        if (done) done_cnt++;
      end
      check("vec_ack",      32'(first_ack), 32'(vecs[k].e_ack));
      check("vec_ack_cnt",  32'(ack_cnt),   32'd1);
      check("vec_note",     32'(note_sel),  32'(vecs[k].e_note));
      check("vec_sound",    32'(sound_cnt), 32'(vecs[k].e_sound));
      check("vec_busy",     32'(busy_cnt),  32'(vecs[k].e_busy));
      check("vec_done_cnt", 32'(done_cnt),  32'd1);
    end

    // Simultaneous requests: requester 2 first, requester 0 after note + gap.
    req = 4'b0101; note_in = 16'h0C0B; dur_in = 32'h0002_0001;
    step();
    check("prio_first_ack", 32'(ack), 32'b0100);
    req = 4'b0001;
    n = 0;
    do begin step(); n++; end while (ack == 0 && n < 100);
    check("prio_second_ack", 32'(ack),      32'b0001);
    check("prio_wait",       32'(n),        32'd13);
    check("prio_note",       32'(note_sel), 32'hB);
    req = 4'b0000;
    drain();

    // Higher request arriving mid-note.
    req = 4'b0001; note_in = 16'h9003; dur_in = 32'h0200_000A;
    step();
    req = 4'b0000;
    done_cnt = 0; sound_hole = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (!sound_en) sound_hole = 1'b1;
    end
    req = 4'b1000;
    n = 0;
    do begin
      step(); n++;
      if (done && ack == 0) done_cnt++;
      if (!sound_en) sound_hole = 1'b1;
    end while (ack == 0 && n < 200);
    check("mid_ack", 32'(ack), 32'b1000);
    check("mid_note", 32'(note_sel), 32'h9);
`ifdef SOUND_ARB_PREEMPT_EN
    check("mid_wait",   32'(n),          32'd1);
    check("mid_done",   32'(done_cnt),   32'd0);
    check("mid_nohole", 32'(sound_hole), 32'd0);
`else
    check("mid_wait",   32'(n),          32'd40);
    check("mid_done",   32'(done_cnt),   32'd1);
`endif
    req = 4'b0000;
    drain();

    // Asynchronous reset in the middle of a note, request held throughout.
    req = 4'b0010; note_in = 16'h0070; dur_in = 32'h0000_0500;
    step();
    for (int i = 0; i < 3; i++) step();
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    check("rst_sound", 32'(sound_en), 32'd0);
    check("rst_busy",  32'(busy),     32'd0);
    check("rst_note",  32'(note_sel), 32'd0);
    @(posedge clk); #1; compare_all();
    @(negedge clk); reset = 1'b0;
    step();
    check("rst_regrant", 32'(ack), 32'b0010);
    req = 4'b0000;
    drain();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        req     = 4'($urandom_range(0, 15));
        note_in = 16'($urandom);
        for (int b = 0; b < 4; b++) dur_in[8*b +: 8] = 8'($urandom_range(0, 3));
      end
      step();
      t_ack = 0;
      for (int b = 0; b < 4; b++) if (ack[b]) t_ack++;
      if (t_ack > 1) check("ack_onehot", 32'(ack), 32'd0);
    end
    req = 4'b0000;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sound_arbiter.md
SOUND_ARBITER -- requirements
Module: sound_arbiter

Interface
REQ-001 Parameter: TICK_DIV, default 50000, clock cycles per duration tick (1 ms at 50 MHz), legal range 2..65535.
REQ-002 Parameter: GAP_TICKS, default 2, silent ticks inserted after a note ends, legal range 0..255.
REQ-003 clk  in  1  system clock; every register is rising-edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 req  in  4  level request per requester; req[3] has highest priority, req[0] lowest.
REQ-006 note_in  in  16  note code per requester; requester i uses bits [4i+3:4i].
REQ-007 dur_in  in  32  duration in ticks per requester; requester i uses bits [8i+7:8i].
REQ-008 ack  out  4  one-cycle registered grant pulse to the accepted requester.
REQ-009 note_sel  out  4  note code driven to the buzzer.
REQ-010 sound_en  out  1  buzzer enable.
REQ-011 active_id  out  2  index of the requester currently granted.
REQ-012 busy  out  1  high in PLAY and GAP.
REQ-013 done  out  1  one-cycle pulse when a note completes normally (not preempted).

Function
REQ-014 FSM states: IDLE, PLAY, GAP; all outputs are registered.
REQ-015 IDLE: if any req bit is high at an edge, the arbiter grants the highest-index set bit on that edge and enters PLAY.
REQ-016 Grant actions on the granting edge: ack[i] pulses high for one cycle; active_id=i; note_sel=note_in[i]; duration counter=dur_in[i]; prescaler=0; sound_en=1.
REQ-017 Prescaler counts 0..TICK_DIV-1 in PLAY and GAP; each wrap decrements the active tick counter by one.
REQ-018 sound_en stays high for exactly dur_in[i]*TICK_DIV cycles after the grant.
REQ-019 PLAY expiry (counter reaches 0): sound_en=0, done pulses, and the FSM enters GAP, or IDLE when GAP_TICKS=0.
REQ-020 GAP holds sound_en=0 for GAP_TICKS*TICK_DIV cycles, then enters IDLE; note_sel holds its last value.
REQ-021 dur_in[i]=0: ack still pulses, sound_en stays 0, done pulses on the cycle after ack, then GAP/IDLE follows per REQ-019.
REQ-022 Requests are not latched; a req still high after its ack is served again after the gap, as a new request.
REQ-023 Requests arriving during GAP are deferred to IDLE and are never dropped while still held.
REQ-024 Simultaneous requests in IDLE resolve by fixed priority; there is no fairness or rotation.
REQ-025 Output ack has at most one bit set in any cycle.

Reset
REQ-026 reset=1 forces the following immediately, without waiting for a clock edge: state IDLE, ack=0, note_sel=0, sound_en=0, active_id=0, busy=0, done=0, prescaler=0, counters=0.
REQ-027 Reset asserted mid-note silences the buzzer immediately; no done pulse is generated.
REQ-028 After reset deasserts, the first grant can occur on the first clock edge.

Configuration
REQ-029 Macro SOUND_ARB_PREEMPT_EN defined: in PLAY or GAP, a req[j] with j>active_id regrants per REQ-016 on the next edge; the preempted note gets no done pulse and no gap is inserted.
REQ-030 With SOUND_ARB_PREEMPT_EN defined, if preemption and expiry occur on the same edge, preemption wins and done does not pulse.
REQ-031 Macro SOUND_ARB_PREEMPT_EN undefined: requests in PLAY and GAP are ignored until IDLE, regardless of priority.

Verification
REQ-032 TICK_DIV=4, GAP_TICKS=1, req[1] with note 5, dur 3 -> ack[1] for 1 cycle, note_sel=5, sound_en high for 12 cycles, done 1 pulse, busy low 4 cycles after sound_en falls.
REQ-033 req=4'b0101 held in IDLE -> ack[2] first; ack[0] only after req[2]'s note and gap complete.
REQ-034 PREEMPT_EN, req[0] dur 10 playing, req[3] note 9 dur 2 after 5 cycles -> ack[3] next edge, note_sel=9 without a sound_en gap, no done for requester 0.
REQ-035 Without PREEMPT_EN, same stimulus -> requester 0 completes 40 cycles with done, then gap, then ack[3].
REQ-036 dur_in=0 request -> ack pulse, sound_en never high, done on the following cycle.
REQ-037 reset pulse mid-PLAY -> sound_en, busy, and note_sel are 0 before the next clk edge; a held request is regranted on the first edge after release.
